// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings, default bit timing and frame width.
package uart_rx_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 87;
  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned IDX_W            = 3;
  localparam int unsigned STATE_W          = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_START = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA  = 3'd2;
  localparam logic [STATE_W-1:0] ST_STOP  = 3'd3;
  localparam logic [STATE_W-1:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous level; resets to 1 so an idle line
// never looks like a start bit coming out of reset.
module uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the line, mid-bit samples each frame and reports
// a good byte (done_flag) or a bad stop bit (frame_err).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 data_rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 active_flag,
  output logic                 done_flag,
  output logic                 frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned LAST  = CLKS_PER_BIT - 1;

  logic                 rx_s;
  logic [STATE_W-1:0]   state,    state_nx;
  logic [CNT_W-1:0]     clk_cnt,  cnt_nx;
  logic [IDX_W-1:0]     bit_idx,  idx_nx;
  logic [DATA_BITS-1:0] shift,    shift_nx;
  logic [DATA_BITS-1:0] data_nx;
  logic                 done_nx;
  logic                 err_nx;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .sys_clk (sys_clk),
    .reset   (reset),
    .d       (data_rx),
    .q       (rx_s)
  );

  // State, datapath and registered outputs
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_out    <= '0;
      done_flag   <= 1'b0;
      frame_err   <= 1'b0;
      active_flag <= 1'b0;
    end else begin
      state       <= state_nx;
      clk_cnt     <= cnt_nx;
      bit_idx     <= idx_nx;
      shift       <= shift_nx;
      data_out    <= data_nx;
      done_flag   <= done_nx;
      frame_err   <= err_nx;
      active_flag <= (state_nx != ST_IDLE);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    cnt_nx   = clk_cnt;
    idx_nx   = bit_idx;
    shift_nx = shift;
    data_nx  = data_out;
    done_nx  = 1'b0;
    err_nx   = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (!rx_s) begin
          state_nx = ST_START;
        end
      end

      ST_START: begin
        if (clk_cnt == CNT_W'(HALF)) begin
          cnt_nx = '0;
          if (!rx_s) begin
            state_nx = ST_DATA;
            idx_nx   = '0;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          cnt_nx = clk_cnt + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (clk_cnt == CNT_W'(LAST)) begin
          cnt_nx           = '0;
          shift_nx[bit_idx] = rx_s;
          if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
            state_nx = ST_STOP;
          end else begin
            idx_nx = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_nx = clk_cnt + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (clk_cnt == CNT_W'(LAST)) begin
          cnt_nx = '0;
          if (rx_s) begin
            data_nx  = shift;
            done_nx  = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            err_nx   = 1'b1;
            state_nx = ST_BREAK;
          end
        end else begin
          cnt_nx = clk_cnt + CNT_W'(1);
        end
      end

      // Hold off until the line recovers so a long low is not seen as a new start
      ST_BREAK: begin
        cnt_nx = '0;
        if (rx_s) begin
          state_nx = ST_IDLE;
        end
      end

      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: a serial-line model drives frames, a monitor logs pulses.
module tb_uart_rx;

  localparam int unsigned CPB    = 87;
  localparam int unsigned HALF_P = 50;

  logic       sys_clk;
  logic       reset;
  logic       data_rx;
  logic [7:0] data_out;
  logic       active_flag;
  logic       done_flag;
  logic       frame_err;

  int checks;
  int errors;

  // Monitor state (written only by the monitor process)
  int         done_cnt;
  int         err_cnt;
  int         both_cnt;
  int         long_cnt;
  int         act_cyc;
  time        done_time;
  logic [7:0] rx_q[$];
  logic       prev_done;
  logic       prev_err;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .data_rx     (data_rx),
    .data_out    (data_out),
    .active_flag (active_flag),
    .done_flag   (done_flag),
    .frame_err   (frame_err)
  );

  initial sys_clk = 1'b0;
  always #(HALF_P) sys_clk = ~sys_clk;

  initial begin
    done_cnt  = 0;
    err_cnt   = 0;
    both_cnt  = 0;
    long_cnt  = 0;
    act_cyc   = 0;
    done_time = 0;
    prev_done = 1'b0;
    prev_err  = 1'b0;
  end

  always @(negedge sys_clk) begin
    if (done_flag) begin
      done_cnt  = done_cnt + 1;
      done_time = $time;
      rx_q.push_back(data_out);
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (done_flag && frame_err) both_cnt = both_cnt + 1;
    if ((done_flag && prev_done) || (frame_err && prev_err)) long_cnt = long_cnt + 1;
    if (active_flag) act_cyc = act_cyc + 1;
    prev_done = done_flag;
    prev_err  = frame_err;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic drive_bit(input logic b);
    data_rx = b;
    wait_clks(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset;
    reset   = 1'b0;
    data_rx = 1'b1;
    wait_clks(2);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
    checks++; if (active_flag !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active_flag); end
    checks++; if (done_flag !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_flag); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", frame_err); end
    reset = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_single;
    int  d0, e0, a0, lat;
    time t0;
    d0 = done_cnt; e0 = err_cnt; a0 = act_cyc;
    t0 = $time;
    send_byte(8'h37, 1'b1);
    wait_clks(2 * CPB);
    lat = int'((done_time - t0) / (2 * HALF_P));
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done_count got %0d want 1", done_cnt - d0); end
    checks++; if (data_out !== 8'h37) begin errors++; $display("FAIL single_data got %h want 37", data_out); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL single_err_count got %0d want 0", err_cnt - e0); end
    // 44 start cycles + 8*87 data + 87 stop = 827
    checks++; if (act_cyc - a0 < 825 || act_cyc - a0 > 829) begin errors++; $display("FAIL single_active_len got %0d want 827", act_cyc - a0); end
    // 9*87 + 43 + 2 + 1 = 829, +/-1 for edge alignment
    checks++; if (lat < 828 || lat > 831) begin errors++; $display("FAIL single_latency got %0d want 829", lat); end
    checks++; if (active_flag !== 1'b0) begin errors++; $display("FAIL single_active_idle got %b want 0", active_flag); end
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = done_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    wait_clks(2 * CPB);
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt - d0); end
    if (done_cnt - d0 == 2) begin
      checks++; if (rx_q[d0] !== 8'hA5) begin errors++; $display("FAIL b2b_first got %h want a5", rx_q[d0]); end
      checks++; if (rx_q[d0+1] !== 8'h5A) begin errors++; $display("FAIL b2b_second got %h want 5a", rx_q[d0+1]); end
    end
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL b2b_data got %h want 5a", data_out); end
  endtask

  task automatic test_frame_err;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hFF, 1'b0);
    data_rx = 1'b0;
    wait_clks(20 * CPB);
    checks++; if (active_flag !== 1'b1) begin errors++; $display("FAIL break_active got %b want 1", active_flag); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL break_err_count got %0d want 1", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL break_done_count got %0d want 0", done_cnt - d0); end
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL break_data got %h want 5a", data_out); end
    data_rx = 1'b1;
    wait_clks(5);
    checks++; if (active_flag !== 1'b0) begin errors++; $display("FAIL break_exit got %b want 0", active_flag); end
    wait_clks(2 * CPB);
    checks++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin errors++; $display("FAIL break_false_frame got done %0d err %0d want 0 1", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_glitch;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    data_rx = 1'b0;
    wait_clks(30);
    data_rx = 1'b1;
    wait_clks(100);
    checks++; if (active_flag !== 1'b0) begin errors++; $display("FAIL glitch_active got %b want 0", active_flag); end
    checks++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_flags got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); end
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL glitch_data got %h want 5a", data_out); end
    send_byte(8'h00, 1'b1);
    wait_clks(2 * CPB);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL glitch_next_count got %0d want 1", done_cnt - d0); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL glitch_next_data got %h want 00", data_out); end
  endtask

  task automatic test_reset_mid;
    int          d0, e0;
    logic [7:0]  b;
    b  = 8'hC3;
    d0 = done_cnt; e0 = err_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    data_rx = b[4];
    wait_clks(CPB / 2);
    reset   = 1'b0;
    data_rx = 1'b1;
    wait_clks(1);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", data_out); end
    checks++; if (active_flag !== 1'b0) begin errors++; $display("FAIL midrst_active got %b want 0", active_flag); end
    checks++; if (done_flag !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL midrst_flags got %b%b want 00", done_flag, frame_err); end
    wait_clks(1);
    reset = 1'b1;
    wait_clks(CPB);
    checks++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin errors++; $display("FAIL midrst_no_flags got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); end
    send_byte(8'h3C, 1'b1);
    wait_clks(2 * CPB);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL midrst_next_count got %0d want 1", done_cnt - d0); end
    checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL midrst_next_data got %h want 3c", data_out); end
  endtask

  task automatic test_pulse_rules;
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL pulse_overlap got %0d want 0", both_cnt); end
    checks++; if (long_cnt !== 0) begin errors++; $display("FAIL pulse_width got %0d long pulses want 0", long_cnt); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    data_rx = 1'b1;
    test_reset;
    test_single;
    test_back_to_back;
    test_frame_err;
    test_glitch;
    test_reset_mid;
    test_pulse_rules;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
